// File: rtl/uart_pkt_pkg.sv
// Constants, state encoding and checksum helper shared by the packet transmitter
// and the packet receiver on the adder link.
package uart_pkt_pkg;

   localparam logic [15:0] PKT_HEADER = 16'hBACD;
   localparam int unsigned PKT_BYTES  = 19;
   localparam int unsigned PKT_BITS   = 152;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      GAP
   } tx_state_t;

   // (hdr + a + b) mod 256 depends only on the low byte of each term.
   function automatic logic [7:0] pkt_checksum(input logic [15:0] hdr,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
      logic [7:0] w_sum;
      w_sum = hdr[7:0] + a[7:0] + b[7:0];
      return w_sum;
   endfunction

endpackage

// File: rtl/uart_packet_tx_byte.sv
// Single-byte 8N1 serialiser with valid/ready/busy/done handshake; back-to-back bytes chain
// without idle time. Optional inter-byte idle bit enabled by UART_PKT_TX_GAP_EN.
module uart_byte_tx
   import uart_pkt_pkg::*;
#(
   parameter int unsigned c_lim = 868
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_ready,
   output logic       o_done
);

   localparam int unsigned TW = (c_lim > 1) ? $clog2(c_lim) : 1;

   tx_state_t       r_state, w_state_nx;
   logic [TW-1:0]   r_timer, w_timer_nx;
   logic [2:0]      r_bit, w_bit_nx;
   logic [7:0]      r_data, w_data_nx;
   logic            r_tx, w_tx_nx;
   logic            r_done, w_done_nx;
   logic            w_tick;

   assign w_tick  = (r_timer == TW'(c_lim - 1));
   // Ready on the last cycle of STOP so the next byte's START follows on the same edge.
   assign o_ready = (r_state == IDLE) || ((r_state == STOP) && w_tick);
   assign o_busy  = (r_state != IDLE);
   assign o_tx    = r_tx;
   assign o_done  = r_done;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_timer <= '0;
         r_bit   <= '0;
         r_data  <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_timer <= w_timer_nx;
         r_bit   <= w_bit_nx;
         r_data  <= w_data_nx;
         r_tx    <= w_tx_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = (r_state == IDLE || w_tick) ? '0 : r_timer + TW'(1);
      w_bit_nx   = r_bit;
      w_data_nx  = r_data;
      w_tx_nx    = r_tx;
      w_done_nx  = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_nx = 1'b1;
            if (i_valid) begin
               w_data_nx  = i_data;
               w_state_nx = START;
               w_tx_nx    = 1'b0;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_nx = DATA;
               w_bit_nx   = 3'd0;
               w_tx_nx    = r_data[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit == 3'd7) begin
                  w_state_nx = STOP;
                  w_tx_nx    = 1'b1;
               end else begin
                  w_bit_nx = r_bit + 3'd1;
                  w_tx_nx  = r_data[r_bit + 3'd1];
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (i_valid) begin
                  w_data_nx  = i_data;
`ifdef UART_PKT_TX_GAP_EN
                  w_state_nx = GAP;
                  w_tx_nx    = 1'b1;
`else
                  w_state_nx = START;
                  w_tx_nx    = 1'b0;
`endif
               end else begin
                  w_state_nx = IDLE;
                  w_tx_nx    = 1'b1;
                  w_done_nx  = 1'b1;
               end
            end
         end
`ifdef UART_PKT_TX_GAP_EN
         GAP: begin
            if (w_tick) begin
               w_state_nx = START;
               w_tx_nx    = 1'b0;
            end
         end
`endif
         default: begin
            w_state_nx = IDLE;
            w_tx_nx    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/uart_packet_tx.sv
// UART 8N1 transmitter for the 19-byte adder-link packet (header, two operands, checksum).
// Optional one-bit idle gap between bytes: define UART_PKT_TX_GAP_EN.
module uart_packet_tx
   import uart_pkt_pkg::*;
#(
   parameter int unsigned c_clkfreq  = 100000000,
   parameter int unsigned c_baudrate = 115200
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [63:0] sayi1_i,
   input  logic [63:0] sayi2_i,
   output logic        tx_o,
   output logic        busy_o,
   output logic        tx_done_o
);

   localparam int unsigned c_lim = c_clkfreq / c_baudrate;

   logic [PKT_BITS-1:0] r_shift;
   logic [4:0]          r_idx;
   logic                w_busy;
   logic                w_ready;
   logic                w_done;
   logic                w_first;
   logic                w_more;
   logic                w_valid;
   logic [7:0]          w_byte;

   // Header MSB goes straight to the serialiser so the start bit leaves on the accept edge;
   // the shift register then holds bytes 1..18 left-aligned.
   assign w_first = start_i & ~w_busy;
   assign w_more  = w_busy & (r_idx != 5'(PKT_BYTES - 1));
   assign w_valid = w_first | w_more;
   assign w_byte  = w_first ? PKT_HEADER[15:8] : r_shift[PKT_BITS-1 -: 8];

   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_shift <= '0;
         r_idx   <= '0;
      end else if (w_first) begin
         r_shift <= {PKT_HEADER[7:0], sayi1_i, sayi2_i,
                     pkt_checksum(PKT_HEADER, sayi1_i, sayi2_i), 8'h00};
         r_idx   <= '0;
      end else if (w_more && w_ready) begin
         r_shift <= r_shift << 8;
         r_idx   <= r_idx + 5'd1;
      end
   end

   uart_byte_tx #(
      .c_lim (c_lim)
   ) u_byte_tx (
      .clk     (clk),
      .i_rst   (rst_i),
      .i_valid (w_valid),
      .i_data  (w_byte),
      .o_tx    (tx_o),
      .o_busy  (w_busy),
      .o_ready (w_ready),
      .o_done  (w_done)
   );

   assign busy_o    = w_busy;
   assign tx_done_o = w_done;

endmodule
